// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES operand-source arbiter.
// Holds the FSM state encoding, source identifiers and counter sizing helper.
package aes_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Beat counter needs at least one bit even for single-beat blocks.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/aes_mux_bank.sv
// Bank of per-bit 2:1 mux cells sharing one select line.
// Kept as its own module so the select fanout stays isolated for timing.
module aes_mux_bank #(
    parameter int WIDTH = 128
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [WIDTH-1:0] out_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign out_o[gi] = sel_i ? in1_i[gi] : in0_i[gi];
        end
    endgenerate

endmodule

// File: rtl/aes_src_arbiter.sv
// Two-source round-robin arbiter feeding the AES round datapath operand input.
// A grant is held for a full block of BEATS accepted beats, then one IDLE cycle follows.
module aes_src_arbiter
    import aes_arb_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int BEATS = 1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             REQ0_VALID,
    input  logic [WIDTH-1:0] REQ0_DATA,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [WIDTH-1:0] REQ1_DATA,
    output logic             REQ1_READY,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    input  logic             OUT_READY,
    output logic             SEL,
    output logic             BUSY
);

    localparam int CW = cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_valid;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ARB_IDLE;
            sel_q   <= SRC0;
            last_q  <= SRC1;   // source 0 wins the first contention
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        OUT_VALID   = 1'b0;
        REQ0_READY  = 1'b0;
        REQ1_READY  = 1'b0;
        grant_valid = sel_q ? REQ1_VALID : REQ0_VALID;

        case (state_q)
            ARB_IDLE: begin
                if (REQ0_VALID || REQ1_VALID) begin
                    if (REQ0_VALID && REQ1_VALID) begin
                        sel_d = ~last_q;
                    end else begin
                        sel_d = REQ1_VALID ? SRC1 : SRC0;
                    end
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                OUT_VALID  = grant_valid;
                REQ0_READY = (sel_q == SRC0) && OUT_READY;
                REQ1_READY = (sel_q == SRC1) && OUT_READY;
                if (grant_valid && OUT_READY) begin
                    if (cnt_q == LAST_BEAT) begin
                        last_d  = sel_q;
                        state_d = ARB_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign SEL  = sel_q;
    assign BUSY = (state_q == ARB_GRANT);

    aes_mux_bank #(
        .WIDTH (WIDTH)
    ) u_mux_bank (
        .sel_i (sel_q),
        .in0_i (REQ0_DATA),
        .in1_i (REQ1_DATA),
        .out_o (OUT_DATA)
    );

endmodule
